// File: rtl/aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer
//
// Iterative AES-128 encryption controller. Loads a key and a plaintext block
// one byte pair at a time, then drives one shared external round datapath
// NR times, and streams the ciphertext out one byte at a time.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   i_in_valid / o_in_ready   byte-pair input handshake
//   i_key_byte, i_state_byte  key / plaintext byte, MSB byte first
//   o_dp_start                one-cycle launch pulse for a round
//   o_dp_round, o_dp_last     round number 1..NR and final-round flag
//   o_dp_state_in, o_dp_key_in  current state and round key registers
//   i_dp_state_out, i_dp_key_out, i_dp_done  round result from datapath
//   o_out_valid / i_out_ready ciphertext byte handshake
//   o_state_out_byte          ciphertext byte, MSB byte first
//   o_busy                    high whenever the controller is not idle
// ---------------------------------------------------------------------------
module aes_round_sequencer #(
   parameter int NR     = 10,
   parameter int NBYTES = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_in_valid,
   output logic         o_in_ready,
   input  logic [7:0]   i_key_byte,
   input  logic [7:0]   i_state_byte,
   output logic         o_dp_start,
   output logic [3:0]   o_dp_round,
   output logic         o_dp_last,
   output logic [127:0] o_dp_state_in,
   output logic [127:0] o_dp_key_in,
   input  logic [127:0] i_dp_state_out,
   input  logic [127:0] i_dp_key_out,
   input  logic         i_dp_done,
   output logic         o_out_valid,
   input  logic         i_out_ready,
   output logic [7:0]   o_state_out_byte,
   output logic         o_busy
);

   localparam logic [4:0] LP_NBYTES = 5'(NBYTES);
   localparam logic [3:0] LP_NR     = 4'(NR);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ARK0,
      S_REQ,
      S_WAIT,
      S_UNLOAD
   } state_t;

   state_t         r_fsm;
   logic [127:0]   r_state;
   logic [127:0]   r_key;
   logic [4:0]     r_cnt;
   logic [3:0]     r_round;
   logic           r_in_ready;
   logic           r_dp_start;
   logic           r_dp_last;
   logic           r_out_valid;
   logic           r_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fsm       <= S_IDLE;
         r_state     <= '0;
         r_key       <= '0;
         r_cnt       <= '0;
         r_round     <= '0;
         r_in_ready  <= 1'b0;
         r_dp_start  <= 1'b0;
         r_dp_last   <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         // dp_start is a single-cycle pulse; it is re-armed only on entry to REQ
         r_dp_start <= 1'b0;
         case (r_fsm)
            S_IDLE: begin
               r_fsm      <= S_LOAD;
               r_in_ready <= 1'b1;
               r_busy     <= 1'b1;
               r_cnt      <= '0;
            end
            S_LOAD: begin
               if (i_in_valid && r_in_ready) begin
                  r_key   <= {r_key[119:0], i_key_byte};
                  r_state <= {r_state[119:0], i_state_byte};
                  r_cnt   <= r_cnt + 5'd1;
                  if (r_cnt == LP_NBYTES - 5'd1) begin
                     r_in_ready <= 1'b0;
                     r_fsm      <= S_ARK0;
                  end
               end
            end
            S_ARK0: begin
               // Initial AddRoundKey is done here, the datapath only runs full rounds
               r_state    <= r_state ^ r_key;
               r_round    <= 4'd1;
               r_dp_last  <= (LP_NR == 4'd1);
               r_dp_start <= 1'b1;
               r_fsm      <= S_REQ;
            end
            S_REQ: begin
               r_fsm <= S_WAIT;
            end
            S_WAIT: begin
               if (i_dp_done) begin
                  r_state <= i_dp_state_out;
                  r_key   <= i_dp_key_out;
                  if (r_round == LP_NR) begin
                     r_cnt       <= '0;
                     r_out_valid <= 1'b1;
                     r_fsm       <= S_UNLOAD;
                  end else begin
                     r_round    <= r_round + 4'd1;
                     r_dp_last  <= ((r_round + 4'd1) == LP_NR);
                     r_dp_start <= 1'b1;
                     r_fsm      <= S_REQ;
                  end
               end
            end
            S_UNLOAD: begin
               if (i_out_ready) begin
                  r_state <= {r_state[119:0], 8'h00};
                  r_cnt   <= r_cnt + 5'd1;
                  if (r_cnt == LP_NBYTES - 5'd1) begin
                     r_out_valid <= 1'b0;
                     r_busy      <= 1'b0;
                     r_fsm       <= S_IDLE;
                  end
               end
            end
            default: begin
               r_fsm <= S_IDLE;
            end
         endcase
      end
   end

   assign o_in_ready       = r_in_ready;
   assign o_dp_start       = r_dp_start;
   assign o_dp_round       = r_round;
   assign o_dp_last        = r_dp_last;
   assign o_dp_state_in    = r_state;
   assign o_dp_key_in      = r_key;
   assign o_out_valid      = r_out_valid;
   // The state register shifts left as bytes leave, so the top byte is always next
   assign o_state_out_byte = r_state[127:120];
   assign o_busy           = r_busy;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_round_sequencer
//
// Testbench for aes_round_sequencer. A behavioural AES round datapath with
// configurable latency answers dp_start pulses; ciphertext is compared with
// a whole-block AES-128 reference model and with known FIPS-197 answers.
// ---------------------------------------------------------------------------
module tb_aes_round_sequencer;

   localparam int NR     = 10;
   localparam int NBYTES = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [7:0]   key_byte;
   logic [7:0]   state_byte;
   logic         dp_start;
   logic [3:0]   dp_round;
   logic         dp_last;
   logic [127:0] dp_state_in;
   logic [127:0] dp_key_in;
   logic [127:0] dp_state_out;
   logic [127:0] dp_key_out;
   logic         dp_done;
   logic         out_valid;
   logic         out_ready;
   logic [7:0]   state_out_byte;
   logic         busy;

   aes_round_sequencer #(.NR(NR), .NBYTES(NBYTES)) dut (
      .clk              (clk),
      .rst              (rst),
      .i_in_valid       (in_valid),
      .o_in_ready       (in_ready),
      .i_key_byte       (key_byte),
      .i_state_byte     (state_byte),
      .o_dp_start       (dp_start),
      .o_dp_round       (dp_round),
      .o_dp_last        (dp_last),
      .o_dp_state_in    (dp_state_in),
      .o_dp_key_in      (dp_key_in),
      .i_dp_state_out   (dp_state_out),
      .i_dp_key_out     (dp_key_out),
      .i_dp_done        (dp_done),
      .o_out_valid      (out_valid),
      .i_out_ready      (out_ready),
      .o_state_out_byte (state_out_byte),
      .o_busy           (busy)
   );

   always #5 clk = ~clk;

   // ---------------- AES reference helpers ----------------
   logic [7:0] sbox [256];

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xt(x);
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [15:0] t = {x, x};
      return t[15-n -: 8];
   endfunction

   function automatic logic [7:0] gb(input logic [127:0] blk, input int i);
      return blk[127-8*i -: 8];
   endfunction

   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o = '0;
      for (int i = 0; i < 16; i++) begin
         int r = i % 4;
         int c = i / 4;
         o[127-8*i -: 8] = sbox[gb(s, r + 4*((c + r) % 4))];
      end
      return o;
   endfunction

   function automatic logic [127:0] mixcol(input logic [127:0] s);
      logic [127:0] o = '0;
      for (int c = 0; c < 4; c++) begin
         logic [7:0] a0 = gb(s, 4*c);
         logic [7:0] a1 = gb(s, 4*c+1);
         logic [7:0] a2 = gb(s, 4*c+2);
         logic [7:0] a3 = gb(s, 4*c+3);
         o[127-32*c -: 8]      = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
         o[127-32*c-8 -: 8]    = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
         o[127-32*c-16 -: 8]   = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
         o[127-32*c-24 -: 8]   = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
      return o;
   endfunction

   function automatic logic [7:0] rcon(input int r);
      logic [7:0] c = 8'h01;
      for (int i = 1; i < r; i++) c = xt(c);
      return c;
   endfunction

   function automatic logic [127:0] next_key(input logic [127:0] k, input int r);
      logic [31:0] w0 = k[127:96];
      logic [31:0] w1 = k[95:64];
      logic [31:0] w2 = k[63:32];
      logic [31:0] w3 = k[31:0];
      logic [31:0] rw = {w3[23:0], w3[31:24]};
      logic [31:0] t  = {sbox[rw[31:24]], sbox[rw[23:16]], sbox[rw[15:8]], sbox[rw[7:0]]};
      logic [31:0] n0, n1, n2, n3;
      t  = t ^ {rcon(r), 24'h000000};
      n0 = w0 ^ t;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
      logic [127:0] s = pt ^ key;
      logic [127:0] k = key;
      for (int r = 1; r <= NR; r++) begin
         k = next_key(k, r);
         s = sub_shift(s);
         if (r < NR) s = mixcol(s);
         s = s ^ k;
      end
      return s;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- checking ----------------
   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- behavioural round datapath ----------------
   int   lat       = 1;     // written by main only
   int   spur_req  = 0;     // written by main only
   int   spur_seen = 0;     // written by responder only
   int   hold_err  = 0;
   int   rnd_log  [$];
   logic last_log [$];

   initial begin
      logic [127:0] cs, ck;
      logic [3:0]   cr;
      logic         cl;
      bit           abort;
      dp_done      = 1'b0;
      dp_state_out = '0;
      dp_key_out   = '0;
      @(posedge clk); #1;
      forever begin
         if (dp_start === 1'b1) begin
            cs = dp_state_in; ck = dp_key_in; cr = dp_round; cl = dp_last;
            rnd_log.push_back(int'(cr));
            last_log.push_back(cl);
            abort = 1'b0;
            for (int j = 0; j < lat; j++) begin
               @(posedge clk); #1;
               if (rst) abort = 1'b1;
               if (!abort && (dp_round !== cr || dp_last !== cl || dp_start !== 1'b0 ||
                              dp_state_in !== cs || dp_key_in !== ck))
                  hold_err++;
            end
            if (!abort) begin
               dp_key_out   = next_key(ck, int'(cr));
               dp_state_out = sub_shift(cs);
               if (int'(cr) != NR) dp_state_out = mixcol(dp_state_out);
               dp_state_out = dp_state_out ^ dp_key_out;
               dp_done      = 1'b1;
               @(posedge clk); #1;
               dp_done      = 1'b0;
               dp_state_out = rnd128();
               dp_key_out   = rnd128();
            end
         end else if (spur_seen != spur_req) begin
            spur_seen++;
            dp_state_out = rnd128();
            dp_key_out   = rnd128();
            dp_done      = 1'b1;
            @(posedge clk); #1;
            dp_done      = 1'b0;
         end else begin
            @(posedge clk); #1;
         end
      end
   end

   // ---------------- stimulus tasks ----------------
   task automatic load_block(input logic [127:0] k, input logic [127:0] p,
                             input bit gaps, input bit spur);
      int   i = 0;
      int   guard = 0;
      logic rdy;
      while (i < NBYTES && guard < 2000) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid   = 1'b0;
            key_byte   = 8'($urandom);
            state_byte = 8'($urandom);
         end else begin
            in_valid   = 1'b1;
            key_byte   = gb(k, i);
            state_byte = gb(p, i);
         end
         rdy = in_ready;
         @(posedge clk); #1;
         guard++;
         if (in_valid && rdy) begin
            i++;
            if (spur && i == 5) spur_req++;
         end
      end
      chk("load_done", 128'(i), 128'(NBYTES));
      // Garbage on the input while not loading must be ignored
      in_valid   = gaps;
      key_byte   = 8'($urandom);
      state_byte = 8'($urandom);
   endtask

   task automatic unload_block(input bit rr, input bit stall, input bit spur,
                               output logic [127:0] ct);
      int         i = 0;
      int         guard = 0;
      int         bad;
      bit         stalled = 1'b0;
      bit         spurred = 1'b0;
      logic       v;
      logic [7:0] b;
      ct = '0;
      while (i < NBYTES && guard < 5000) begin
         if (stall && i == 7 && !stalled) begin
            stalled   = 1'b1;
            out_ready = 1'b0;
            b   = state_out_byte;
            bad = 0;
            repeat (20) begin
               @(posedge clk); #1;
               if (out_valid !== 1'b1 || state_out_byte !== b) bad++;
            end
            chk("stall_hold", 128'(bad), 128'(0));
         end
         if (spur && i == 3 && !spurred) begin
            spurred   = 1'b1;
            out_ready = 1'b0;
            b = state_out_byte;
            spur_req++;
            repeat (4) begin
               @(posedge clk); #1;
            end
            chk("spur_unload_hold", 128'({out_valid, state_out_byte}), 128'({1'b1, b}));
         end
         out_ready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
         v = out_valid;
         b = state_out_byte;
         @(posedge clk); #1;
         guard++;
         if (v && out_ready) begin
            ct[127-8*i -: 8] = b;
            i++;
         end
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("unload_done", 128'(i), 128'(NBYTES));
      chk("busy_after", 128'(busy), 128'(0));
      chk("ovalid_after", 128'(out_valid), 128'(0));
   endtask

   task automatic do_block(input string tag, input logic [127:0] k, input logic [127:0] p,
                           input int L, input bit gaps, input bit spur, input bit stall,
                           input bit rr, output logic [127:0] ct);
      int base, hbase, n, bad;
      lat   = L;
      base  = rnd_log.size();
      hbase = hold_err;
      load_block(k, p, gaps, spur);
      n = 1;
      while (out_valid !== 1'b1 && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_latency"}, 128'(n), 128'(2 + NR*(L+1)));
      unload_block(rr, stall, spur, ct);
      chk({tag, "_ct_model"}, ct, aes_ref(k, p));
      chk({tag, "_dp_starts"}, 128'(rnd_log.size() - base), 128'(NR));
      bad = 0;
      for (int j = 0; j < NR && base + j < rnd_log.size(); j++)
         if (rnd_log[base+j] != j + 1 || last_log[base+j] !== (j + 1 == NR)) bad++;
      chk({tag, "_round_seq"}, 128'(bad), 128'(0));
      chk({tag, "_dp_hold"}, 128'(hold_err - hbase), 128'(0));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"},  128'(in_ready), 128'(0));
      chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
      chk({tag, "_dp_start"},  128'(dp_start), 128'(0));
      chk({tag, "_dp_round"},  128'(dp_round), 128'(0));
      chk({tag, "_dp_last"},   128'(dp_last), 128'(0));
      chk({tag, "_busy"},      128'(busy), 128'(0));
      chk({tag, "_out_byte"},  128'(state_out_byte), 128'(0));
      chk({tag, "_state_reg"}, dp_state_in, 128'(0));
      chk({tag, "_key_reg"},   dp_key_in, 128'(0));
   endtask

   // ---------------- main sequence ----------------
   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] ZERO_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   initial begin
      logic [127:0] ct, k, p;
      int           base, guard;

      // S-box built from the GF(2^8) inverse plus the affine transform
      for (int a = 0; a < 256; a++) begin
         logic [7:0] inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end

      rst        = 1'b1;
      in_valid   = 1'b0;
      key_byte   = 8'h00;
      state_byte = 8'h00;
      out_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("por");
      rst = 1'b0;

      // FIPS-197 C.1, single-cycle datapath
      do_block("fips_l1", FIPS_KEY, FIPS_PT, 1, 1'b0, 1'b0, 1'b0, 1'b0, ct);
      chk("fips_l1_ct", ct, FIPS_CT);

      // Same vector, slow datapath, input gaps, output stall at byte 7
      do_block("fips_l5", FIPS_KEY, FIPS_PT, 5, 1'b1, 1'b0, 1'b1, 1'b0, ct);
      chk("fips_l5_ct", ct, FIPS_CT);

      // Reset while waiting on round 5
      lat  = 5;
      base = rnd_log.size();
      load_block(rnd128(), rnd128(), 1'b0, 1'b0);
      guard = 0;
      while (rnd_log.size() < base + 5 && guard < 2000) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("rst_reach_round5", 128'(rnd_log.size() - base), 128'(5));
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk_reset_outputs("midrst");
      @(posedge clk); #1;
      rst = 1'b0;

      // Fresh block after abort, with spurious dp_done in LOAD and UNLOAD
      k = rnd128();
      p = rnd128();
      do_block("after_rst", k, p, 3, 1'b1, 1'b1, 1'b0, 1'b1, ct);

      // All-zero key and plaintext
      do_block("zero", '0, '0, 2, 1'b0, 1'b0, 1'b0, 1'b0, ct);
      chk("zero_ct", ct, ZERO_CT);

      // Random blocks with random latency and consumer backpressure
      for (int b = 0; b < 3; b++) begin
         k = rnd128();
         p = rnd128();
         do_block($sformatf("rand%0d", b), k, p, int'($urandom_range(1, 4)),
                  1'b1, 1'b0, 1'b0, 1'b1, ct);
      end

      repeat (4) @(posedge clk);
      #1;
      chk("spur_issued", 128'(spur_seen), 128'(spur_req));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "simulation did not complete");
   end

endmodule
